store_id: RTL

STORE_ID -- requirements
Module: store_id

---
 rtl/store_id.sv | 118 +++++++++++
 1 files changed

// File: rtl/store_id.sv
// Enrollment controller: collects a 4-digit ID, scans the
// external ID table for a duplicate, then appends it.
module store_id #(
  parameter int MAX_USERS = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  InputSwitches,
  input  logic        EnterPswd,
  input  logic        Enroll,
  input  logic        Cancel,
  output logic [4:0]  RdAddr,
  input  logic [15:0] RdData,
  output logic        WrEn,
  output logic [4:0]  WrAddr,
  output logic [15:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        DupErr,
  output logic        Full,
  output logic [4:0]  SlotID,
  output logic [5:0]  UserCount
);

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] DIG0   = 4'd1;
  localparam logic [3:0] DIG1   = 4'd2;
  localparam logic [3:0] DIG2   = 4'd3;
  localparam logic [3:0] DIG3   = 4'd4;
  localparam logic [3:0] SEARCH = 4'd5;
  localparam logic [3:0] CMP    = 4'd6;
  localparam logic [3:0] WRITE  = 4'd7;
  localparam logic [3:0] DONE   = 4'd8;
  localparam logic [3:0] ERR    = 4'd9;

  logic [3:0]  state;
  logic [3:0]  d0, d1, d2, d3;
  logic [4:0]  idx;
  logic [15:0] pid;
  logic        last;

  assign pid  = {d0, d1, d2, d3};
  assign last = ({1'b0, idx} == UserCount - 6'd1);
  assign Full = (UserCount == 6'(MAX_USERS));

  // Table ports and status flags are pure decodes of state/registers
  assign RdAddr = idx;
  assign WrEn   = (state == WRITE);
  assign WrAddr = UserCount[4:0];
  assign WrData = pid;
  assign Busy   = (state != IDLE);
  assign Done   = (state == DONE);
  assign DupErr = (state == ERR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      d0        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      idx       <= '0;
      SlotID    <= '0;
      UserCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Enroll && !Full)
            state <= DIG0;
        end
        DIG0, DIG1, DIG2, DIG3: begin
          if (Cancel) begin
            state <= IDLE;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
          end else if (EnterPswd) begin
            unique case (state)
              DIG0:    d0 <= InputSwitches;
              DIG1:    d1 <= InputSwitches;
              DIG2:    d2 <= InputSwitches;
              default: d3 <= InputSwitches;
            endcase
            idx <= '0;
            if (state != DIG3)
              state <= state + 4'd1;
            else if (UserCount == 6'd0)
              state <= WRITE;
            else
              state <= SEARCH;
          end
        end
        SEARCH: state <= CMP;
        CMP: begin
          if (RdData == pid) begin
            state <= ERR;
          end else if (last) begin
            state <= WRITE;
          end else begin
            idx   <= idx + 5'd1;
            state <= SEARCH;
          end
        end
        WRITE: state <= DONE;
        DONE: begin
          SlotID <= UserCount[4:0];
          if (UserCount < 6'(MAX_USERS))
            UserCount <= UserCount + 6'd1;
          state <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
